// File: rtl/product_accumulator.sv
// Sums a batch of COUNT accepted multiplier products into a registered result,
// pulsing done at batch end and flagging a sticky saturation for that batch.
module product_accumulator #(
  parameter int PW    = 6,
  parameter int ACC_W = 9,
  parameter int COUNT = 8,
  parameter int CW    = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prod_valid,
  input  logic [PW-1:0]    prod,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             sat;

  logic [ACC_W:0]   acc_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             last;

  // One extra bit catches the carry out so the add can clamp instead of wrap.
  assign acc_wide = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, prod};
  assign add_ovf  = acc_wide[ACC_W];
  assign acc_next = add_ovf ? ACC_MAX : acc_wide[ACC_W-1:0];
  assign last     = (count == CW'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      sat      <= 1'b0;
      count    <= '0;
      sum      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (prod_valid) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            sat   <= sat | add_ovf;
            // The final product goes straight into the published result.
            if (last) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              sum      <= acc_next;
              overflow <= sat | add_ovf;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
